// File: rtl/loop_buffer_replay.sv
// Loop buffer: captures a short backward-branch loop body from fetch while the
// detector is buffering, then replays it to IFID in program order while reuse is active.
module loop_buffer_replay #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture_en,
  input  logic              capture_valid,
  input  logic [DATA_W-1:0] capture_instr,
  input  logic [DATA_W-1:0] capture_pc,
  input  logic              reuse_signal,
  input  logic              flush,
  input  logic              stall,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [DATA_W-1:0] out_pc,
  output logic [ADDR_W:0]   loop_len,
  output logic              overflow
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_READY   = 2'd2,
    ST_REPLAY  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LEN_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ZERO  = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  state_t              state_r, state_nx_s;
  logic [ADDR_W:0]     wr_ptr_r, wr_ptr_nx_s;
  logic [ADDR_W-1:0]   rd_ptr_r, rd_ptr_nx_s;
  logic [ADDR_W:0]     loop_len_r, loop_len_nx_s;
  logic                out_valid_r, out_valid_nx_s;
  logic [DATA_W-1:0]   out_instr_r, out_instr_nx_s;
  logic [DATA_W-1:0]   out_pc_r, out_pc_nx_s;
  logic                overflow_r, overflow_nx_s;

  // Each entry holds {pc, instr}; contents are meaningless while loop_len is 0.
  logic [2*DATA_W-1:0] mem_r [DEPTH];
  logic                mem_we_s;
  logic [ADDR_W-1:0]   mem_waddr_s;
  logic [2*DATA_W-1:0] rd_entry_s;
  logic [2*DATA_W-1:0] first_entry_s;
  logic                last_entry_s;

  assign rd_entry_s    = mem_r[rd_ptr_r];
  assign first_entry_s = mem_r[PTR_ZERO];
  assign last_entry_s  = ({1'b0, rd_ptr_r} == (loop_len_r - LEN_ONE));

  // Next-state, pointer, output and write-enable computation.
  always_comb begin
    state_nx_s     = state_r;
    wr_ptr_nx_s    = wr_ptr_r;
    rd_ptr_nx_s    = rd_ptr_r;
    loop_len_nx_s  = loop_len_r;
    out_valid_nx_s = out_valid_r;
    out_instr_nx_s = out_instr_r;
    out_pc_nx_s    = out_pc_r;
    overflow_nx_s  = 1'b0;
    mem_we_s       = 1'b0;
    mem_waddr_s    = wr_ptr_r[ADDR_W-1:0];

    if (flush) begin
      state_nx_s     = ST_IDLE;
      loop_len_nx_s  = LEN_ZERO;
      out_valid_nx_s = 1'b0;
      rd_ptr_nx_s    = PTR_ZERO;
    end else begin
      case (state_r)
        ST_IDLE, ST_READY: begin
          if ((state_r == ST_READY) && reuse_signal) begin
            state_nx_s     = ST_REPLAY;
            out_valid_nx_s = 1'b1;
            out_pc_nx_s    = first_entry_s[2*DATA_W-1:DATA_W];
            out_instr_nx_s = first_entry_s[DATA_W-1:0];
            rd_ptr_nx_s    = (loop_len_r == LEN_ONE) ? PTR_ZERO : PTR_ONE;
          end else if (capture_en) begin
            // Starting (or restarting) a capture writes entry 0 on this same edge.
            state_nx_s     = ST_CAPTURE;
            loop_len_nx_s  = LEN_ZERO;
            out_valid_nx_s = 1'b0;
            mem_waddr_s    = PTR_ZERO;
            if (capture_valid) begin
              mem_we_s    = 1'b1;
              wr_ptr_nx_s = LEN_ONE;
            end else begin
              wr_ptr_nx_s = LEN_ZERO;
            end
          end else begin
            out_valid_nx_s = 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (!capture_en) begin
            loop_len_nx_s = wr_ptr_r;
            state_nx_s    = (wr_ptr_r != LEN_ZERO) ? ST_READY : ST_IDLE;
          end else if (capture_valid) begin
            if (wr_ptr_r < DEPTH_L) begin
              mem_we_s    = 1'b1;
              wr_ptr_nx_s = wr_ptr_r + LEN_ONE;
            end else begin
              overflow_nx_s = 1'b1;
              loop_len_nx_s = LEN_ZERO;
              state_nx_s    = ST_IDLE;
            end
          end else begin
            wr_ptr_nx_s = wr_ptr_r;
          end
        end
        ST_REPLAY: begin
          if (!reuse_signal) begin
            state_nx_s     = ST_IDLE;
            out_valid_nx_s = 1'b0;
            loop_len_nx_s  = LEN_ZERO;
          end else if (!stall) begin
            out_pc_nx_s    = rd_entry_s[2*DATA_W-1:DATA_W];
            out_instr_nx_s = rd_entry_s[DATA_W-1:0];
            rd_ptr_nx_s    = last_entry_s ? PTR_ZERO : (rd_ptr_r + PTR_ONE);
          end else begin
            rd_ptr_nx_s = rd_ptr_r;
          end
        end
        default: begin
          state_nx_s     = ST_IDLE;
          out_valid_nx_s = 1'b0;
          loop_len_nx_s  = LEN_ZERO;
        end
      endcase
    end
  end

  // State, pointer and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      wr_ptr_r    <= LEN_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      loop_len_r  <= LEN_ZERO;
      out_valid_r <= 1'b0;
      out_instr_r <= DATA_ZERO;
      out_pc_r    <= DATA_ZERO;
      overflow_r  <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      wr_ptr_r    <= wr_ptr_nx_s;
      rd_ptr_r    <= rd_ptr_nx_s;
      loop_len_r  <= loop_len_nx_s;
      out_valid_r <= out_valid_nx_s;
      out_instr_r <= out_instr_nx_s;
      out_pc_r    <= out_pc_nx_s;
      overflow_r  <= overflow_nx_s;
    end
  end

  // Loop body storage; not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s && !reset) begin
      mem_r[mem_waddr_s] <= {capture_pc, capture_instr};
    end
  end

  assign out_valid = out_valid_r;
  assign out_instr = out_instr_r;
  assign out_pc    = out_pc_r;
  assign loop_len  = loop_len_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_loop_buffer_replay.sv
// Self-checking bench for loop_buffer_replay: directed scenarios with literal
// expectations plus randomized traffic against a queue-based behavioural model.
module tb_loop_buffer_replay;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset, capture_en, capture_valid, reuse_signal, flush, stall;
  logic [DATA_W-1:0] capture_instr, capture_pc;
  logic              out_valid, overflow;
  logic [DATA_W-1:0] out_instr, out_pc;
  logic [ADDR_W:0]   loop_len;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: the captured body is a queue of {pc, instr}.
  logic [63:0] m_buf[$];
  bit          m_cap, m_ready, m_rep, m_outs_known, m_ov, m_ovalid;
  int          m_idx, m_len;
  logic [31:0] m_opc, m_oinstr;

  always #5 clk = ~clk;

  loop_buffer_replay #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .capture_en(capture_en), .capture_valid(capture_valid),
    .capture_instr(capture_instr), .capture_pc(capture_pc), .reuse_signal(reuse_signal),
    .flush(flush), .stall(stall), .out_valid(out_valid), .out_instr(out_instr),
    .out_pc(out_pc), .loop_len(loop_len), .overflow(overflow)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic begin_capture();
    m_buf.delete();
    m_cap = 1'b1;
    if (capture_valid) m_buf.push_back({capture_pc, capture_instr});
  endtask

  task automatic model_step();
    m_ov = 1'b0;
    if (reset) begin
      m_buf.delete();
      m_cap = 0; m_ready = 0; m_rep = 0; m_len = 0; m_idx = 0;
      m_ovalid = 0; m_opc = 32'h0; m_oinstr = 32'h0; m_outs_known = 1;
    end else if (flush) begin
      m_buf.delete();
      m_cap = 0; m_ready = 0; m_rep = 0; m_len = 0; m_ovalid = 0; m_outs_known = 0;
    end else if (m_rep) begin
      if (!reuse_signal) begin
        m_rep = 0; m_ovalid = 0; m_len = 0; m_outs_known = 0;
      end else if (!stall) begin
        {m_opc, m_oinstr} = m_buf[m_idx];
        m_idx = (m_idx + 1) % m_len;
      end
    end else if (m_ready) begin
      if (reuse_signal) begin
        m_ready = 0; m_rep = 1; m_ovalid = 1;
        {m_opc, m_oinstr} = m_buf[0];
        m_idx = 1 % m_len;
      end else if (capture_en) begin
        m_ready = 0; m_len = 0;
        begin_capture();
      end
    end else if (m_cap) begin
      if (!capture_en) begin
        m_cap = 0;
        m_len = m_buf.size();
        m_ready = (m_len > 0);
      end else if (capture_valid) begin
        if (m_buf.size() < DEPTH) m_buf.push_back({capture_pc, capture_instr});
        else begin
          m_ov = 1; m_len = 0; m_cap = 0;
          m_buf.delete();
        end
      end
    end else if (capture_en) begin
      begin_capture();
    end
  endtask

  // One clock: inputs are already stable; sample #1 after the edge and compare to the model.
  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    chk("out_valid", 64'(out_valid), 64'(m_ovalid));
    chk("loop_len", 64'(loop_len), 64'(m_len));
    chk("overflow", 64'(overflow), 64'(m_ov));
    if (m_ovalid || m_outs_known) begin
      chk("out_pc", 64'(out_pc), 64'(m_opc));
      chk("out_instr", 64'(out_instr), 64'(m_oinstr));
    end
  endtask

  task automatic set_quiet();
    reset = 0; capture_en = 0; capture_valid = 0; reuse_signal = 0;
    flush = 0; stall = 0; capture_pc = 32'h0; capture_instr = 32'h0;
  endtask

  task automatic capture_body(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      capture_en = 1; capture_valid = 1;
      capture_pc = base + 32'(4 * i);
      capture_instr = instr_of(capture_pc);
      tick();
    end
    capture_en = 0; capture_valid = 0;
    tick();
  endtask

  initial begin
    set_quiet();
    reset = 1;
    tick(); tick();
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_pc", 64'(out_pc), 64'h0);
    chk("rst_len", 64'(loop_len), 64'h0);
    reset = 0;
    tick();

    // 1: four-entry loop replays in order and wraps
    capture_body(4, 32'h100);
    chk("t1_len", 64'(loop_len), 64'h4);
    reuse_signal = 1;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] exp_pc;
      exp_pc = 32'h100 + 32'(4 * (i % 4));
      tick();
      chk("t1_pc", 64'(out_pc), 64'(exp_pc));
      chk("t1_instr", 64'(out_instr), 64'(instr_of(exp_pc)));
    end
    reuse_signal = 0;
    tick();
    chk("t1_end_len", 64'(loop_len), 64'h0);

    // 2: stall holds output
    capture_body(3, 32'h200);
    reuse_signal = 1;
    tick(); chk("t2_pc0", 64'(out_pc), 64'h200);
    tick(); chk("t2_pc1", 64'(out_pc), 64'h204);
    stall = 1;
    tick(); chk("t2_hold1", 64'(out_pc), 64'h204);
    tick(); chk("t2_hold2", 64'(out_instr), 64'(instr_of(32'h204)));
    stall = 0;
    tick(); chk("t2_pc2", 64'(out_pc), 64'h208);
    tick(); chk("t2_wrap", 64'(out_pc), 64'h200);
    reuse_signal = 0;
    tick();

    // 3: 33 valid instructions overflow
    for (int i = 0; i < 33; i++) begin
      capture_en = 1; capture_valid = 1;
      capture_pc = 32'h300 + 32'(4 * i);
      capture_instr = instr_of(capture_pc);
      tick();
      if (i == 31) chk("t3_no_ov_yet", 64'(overflow), 64'h0);
    end
    chk("t3_ov", 64'(overflow), 64'h1);
    chk("t3_len", 64'(loop_len), 64'h0);
    capture_en = 0; capture_valid = 0;
    tick();
    chk("t3_ov_pulse", 64'(overflow), 64'h0);
    reuse_signal = 1;
    tick(); tick();
    chk("t3_no_replay", 64'(out_valid), 64'h0);
    reuse_signal = 0;
    tick();

    // 4: flush together with reuse mid-replay
    capture_body(3, 32'h400);
    reuse_signal = 1;
    tick(); tick();
    flush = 1;
    tick();
    chk("t4_valid", 64'(out_valid), 64'h0);
    chk("t4_len", 64'(loop_len), 64'h0);
    flush = 0;
    tick();
    chk("t4_idle", 64'(out_valid), 64'h0);
    reuse_signal = 0;
    tick();

    // 5: bubbles inside the capture window
    for (int i = 0; i < 6; i++) begin
      capture_en = 1;
      capture_valid = (i == 0 || i == 2 || i == 5);
      capture_pc = 32'h500 + 32'(4 * i);
      capture_instr = instr_of(capture_pc);
      tick();
    end
    capture_en = 0; capture_valid = 0;
    tick();
    chk("t5_len", 64'(loop_len), 64'h3);
    reuse_signal = 1;
    tick(); chk("t5_pc0", 64'(out_pc), 64'h500);
    tick(); chk("t5_pc1", 64'(out_pc), 64'h508);
    tick(); chk("t5_pc2", 64'(out_pc), 64'h514);
    tick(); chk("t5_pc3", 64'(out_pc), 64'h500);
    reuse_signal = 0;
    tick();

    // 6: reset mid-replay, then a fresh capture
    capture_body(2, 32'h600);
    reuse_signal = 1;
    tick(); tick();
    reset = 1;
    tick();
    chk("t6_valid", 64'(out_valid), 64'h0);
    chk("t6_pc", 64'(out_pc), 64'h0);
    chk("t6_instr", 64'(out_instr), 64'h0);
    chk("t6_len", 64'(loop_len), 64'h0);
    reset = 0; reuse_signal = 0;
    tick();
    capture_body(2, 32'h700);
    chk("t6_len2", 64'(loop_len), 64'h2);
    reuse_signal = 1;
    tick(); chk("t6_pc0", 64'(out_pc), 64'h700);
    tick(); chk("t6_pc1", 64'(out_pc), 64'h704);
    tick(); chk("t6_pc2", 64'(out_pc), 64'h700);
    reuse_signal = 0;
    tick();

    // Randomized episodes: capture window, gap, replay window
    for (int ep = 0; ep < 150; ep++) begin
      int n_cap, n_gap, n_rep;
      n_cap = $urandom_range(0, 40);
      n_gap = $urandom_range(0, 2);
      n_rep = $urandom_range(0, 40);
      for (int c = 0; c < n_cap; c++) begin
        capture_en = 1;
        capture_valid = ($urandom_range(0, 3) != 0);
        capture_pc = $urandom; capture_instr = $urandom;
        flush = ($urandom_range(0, 59) == 0);
        reset = ($urandom_range(0, 299) == 0);
        tick();
      end
      flush = 0; reset = 0;
      capture_en = 0; capture_valid = 0;
      tick();
      for (int g = 0; g < n_gap; g++) begin
        capture_en = ($urandom_range(0, 9) == 0);
        capture_valid = 1;
        capture_pc = $urandom; capture_instr = $urandom;
        tick();
      end
      capture_en = 0;
      for (int r = 0; r < n_rep; r++) begin
        reuse_signal = 1;
        stall = ($urandom_range(0, 3) == 0);
        capture_en = ($urandom_range(0, 1) == 0);
        capture_valid = ($urandom_range(0, 1) == 0);
        capture_pc = $urandom; capture_instr = $urandom;
        flush = ($urandom_range(0, 59) == 0);
        reset = ($urandom_range(0, 199) == 0);
        tick();
      end
      set_quiet();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
